// File: rtl/dmem_readback_if.sv
// Bundle of control, data-memory second-port and output-stream signals for dmem_readback.
// master = the readback agent, slave = its environment (controller, memory and consumer).
interface dmem_readback_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;

  logic             te;
  logic [31:0]      ta;
  logic [31:0]      td;
  logic [31:0]      rtd;

  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;

  logic             busy;
  logic             done;

  modport master (
    input  start, abort, base_addr, word_count, rtd, out_ready,
    output te, ta, td, out_data, out_valid, busy, done
  );

  modport slave (
    output start, abort, base_addr, word_count, rtd, out_ready,
    input  te, ta, td, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/dmem_readback.sv
// Streams word_count consecutive words out of a data memory's second (read-only) port
// onto a valid/ready output with a single output register.
module dmem_readback #(
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_readback_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic             all_issued;
  logic             handshake;
  logic             load;
  logic [31:0]      run_addr;

  // idx_q doubles as the issued-word count: it advances exactly once per load.
  assign all_issued = (idx_q == count_q);
  assign handshake  = out_valid_q && bus.out_ready;
  assign load       = (state_q == RUN) && !all_issued && (!out_valid_q || bus.out_ready);
  assign run_addr   = base_q + (32'(idx_q) * 32'(ADDR_STEP));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d      = {bus.base_addr[31:2], 2'b00};
          count_d     = bus.word_count;
          idx_d       = '0;
          out_valid_d = 1'b0;
          state_d     = (bus.word_count == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        // abort wins over both load and handshake; the pending word is dropped
        if (bus.abort) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          if (load) begin
            out_data_d  = bus.rtd;
            out_valid_d = 1'b1;
            idx_d       = idx_q + CNT_W'(1);
          end else if (handshake) begin
            out_valid_d = 1'b0;
          end
          if (handshake && all_issued) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.te        = 1'b0;
  assign bus.td        = 32'h0;
  assign bus.ta        = (state_q == RUN) ? run_addr : base_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);

endmodule

// File: doc/dmem_readback.md
DMEM_READBACK -- requirements
Module: dmem_readback

Interface
REQ-001 Parameter CNT_W, default 8: width of the word-count input and the internal word index.
REQ-002 Parameter ADDR_STEP, default 4: byte increment between consecutive reads (word-addressed data memory).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  one-cycle request to begin a readback; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a readback in progress.
REQ-007 base_addr  input  32  byte address of the first word; bits [1:0] ignored and forced to 0.
REQ-008 word_count  input  CNT_W  number of words to read; 0 is legal.
REQ-009 te  output  1  data-memory second-port write enable; tied to 0 (read-only agent).
REQ-010 ta  output  32  data-memory second-port address.
REQ-011 td  output  32  data-memory second-port write data; tied to 0.
REQ-012 rtd  input  32  data-memory second-port read data; combinational read of ta, valid in the same cycle.
REQ-013 out_data  output  32  registered stream data.
REQ-014 out_valid  output  1  out_data holds an unconsumed word.
REQ-015 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both 1 at a rising edge.
REQ-016 busy  output  1  1 in RUN state.
REQ-017 done  output  1  one-cycle pulse when a readback completes or aborts.

Function
REQ-018 States: IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-019 IDLE and start=1: latch base_addr (bits [1:0] = 0) and word_count, clear index and issued-word count, go to RUN; word_count=0 goes to DONE instead, with no word emitted.
REQ-020 start is ignored outside IDLE.
REQ-021 ta = latched base + index*ADDR_STEP, modulo 2^32 (wraps silently past 0xFFFFFFFC); ta = latched base in IDLE and DONE.
REQ-022 Load condition in RUN: words issued < word_count AND (out_valid=0 OR out_ready=1).
REQ-023 On load: out_data <= rtd, out_valid <= 1, index increments; sustained throughput is 1 word/cycle while out_ready=1.
REQ-024 Handshake without load: out_valid <= 0.
REQ-025 out_valid=1 and out_ready=0: out_data, out_valid and ta hold stable.
REQ-026 Latency: first word is valid on out_valid the cycle after RUN is entered.
REQ-027 RUN exits to DONE in the cycle in which the final word's handshake occurs, and only when all word_count words have been issued.
REQ-028 abort=1 in RUN: next state DONE, out_valid <= 0, and the pending word is discarded; abort has priority over load and handshake.
REQ-029 abort in IDLE or DONE has no effect.
REQ-030 done = 1 only in the DONE state.
REQ-031 Index and count comparisons use CNT_W bits; word_count = 2^CNT_W-1 reads exactly that many words.

Reset
REQ-032 reset=0 asynchronously forces: state IDLE, out_valid=0, out_data=0, busy=0, done=0, index=0, latched base=0.
REQ-033 Reset mid-RUN discards all progress; no done pulse follows.
REQ-034 After reset is released, the first start is honoured no earlier than the first rising edge at which reset=1.

Verification
REQ-035 base=0x100, count=4, out_ready=1, memory[i]=0xA0+i -> out_data 0xA0..0xA3 on 4 consecutive cycles, ta 0x100..0x10C, then done=1 for one cycle.
REQ-036 count=3, out_ready low for 2 cycles after the first word -> word 0 held stable for 3 cycles, all 3 words delivered in order, no duplicates and no losses.
REQ-037 count=0 and start -> done pulses the next cycle, out_valid never rises, busy stays 0.
REQ-038 base=0xFFFFFFF8, count=4 -> ta sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-039 abort after 2 of 5 words -> out_valid=0 next cycle, done one pulse, IDLE; a following start with count=1 works normally.
REQ-040 reset=0 asserted mid-RUN (asynchronous, between edges) -> outputs clear immediately, te=0 throughout, no done pulse.
